// File: rtl/ram_copy_master_if.sv
// RAM port bundle between the copy engine (master) and the single-port data RAM (slave).
interface ram_copy_master_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_addr, mem_we, mem_wdata, input  mem_rdata);
    modport slave  (input  mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_copy_master.sv
// Block copy engine on a single-port, one-cycle synchronous-read RAM.
// Defining RAM_COPY_FILL_EN adds a fill mode (fill / fill_val ports).
module ram_copy_master #(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
`ifdef RAM_COPY_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
`endif
    output logic          busy,
    output logic          done,
    ram_copy_master_if.master mem
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    typedef struct packed {
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        logic [AW-1:0] cnt;
    } xfer_t;

    state_t state, state_nxt;
    xfer_t  xf;
    logic   accept;
    logic   last;
    logic   fill_in;
    logic   fill_mode;
    logic [DW-1:0] fill_data;

    assign accept = (state == IDLE) && start && (len != '0);
    assign last   = (xf.cnt == AW'(1));

`ifdef RAM_COPY_FILL_EN
    logic          fill_q;
    logic [DW-1:0] fill_val_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (accept) begin
            fill_q     <= fill;
            fill_val_q <= fill_val;
        end
    end

    assign fill_in   = fill;
    assign fill_mode = fill_q;
    assign fill_data = fill_val_q;
`else
    assign fill_in   = 1'b0;
    assign fill_mode = 1'b0;
    assign fill_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Transfer context: loaded on accept, stepped once per written word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xf <= '0;
        end else if (accept) begin
            xf <= '{sa: src, da: dst, cnt: len};
        end else if (state == WR) begin
            xf.sa  <= xf.sa  + AW'(1);
            xf.da  <= xf.da  + AW'(1);
            xf.cnt <= xf.cnt - AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (len == '0) ? FIN : (fill_in ? WR : RD);
            RD:   state_nxt = WR;
            WR:   state_nxt = last ? FIN : (fill_mode ? WR : RD);
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data passes straight through on WR; the RAM holds it while we=1.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        unique case (state)
            RD: begin
                busy         = 1'b1;
                mem.mem_addr = xf.sa;
            end
            WR: begin
                busy          = 1'b1;
                mem.mem_addr  = xf.da;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = fill_mode ? fill_data : mem.mem_rdata;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_copy_master.sv
// Randomized bench for ram_copy_master with a word-level RAM reference model.
module tb_ram_copy_master;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int M  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src, dst, len;
    logic          fill;
    logic [DW-1:0] fill_val;
    logic          busy, done;

    int n_chk = 0;
    int n_err = 0;
    int done_total = 0;
    int we_total = 0;

    logic [DW-1:0] ram     [1<<AW];
    logic [DW-1:0] exp_ram [1<<AW];
    logic [DW-1:0] rdata_q;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    ram_copy_master_if #(.DW(DW), .AW(AW)) bus ();

    ram_copy_master #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
`ifdef RAM_COPY_FILL_EN
        .fill     (fill),
        .fill_val (fill_val),
`endif
        .busy     (busy),
        .done     (done),
        .mem      (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM: read data registered, held while writing.
    always @(posedge clk) begin
        if (pre_we)          ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        else                 rdata_q <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    always @(negedge clk) begin
        if (done)       done_total++;
        if (bus.mem_we) we_total++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke_ram(input int a, input logic [DW-1:0] v);
        pre_we = 1'b1; pre_addr = AW'(a); pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
        exp_ram[a & M] = v;
    endtask

    task automatic cmp_ram(input string tag);
        int nbad = 0;
        for (int i = 0; i <= M; i++) if (ram[i] !== exp_ram[i]) nbad++;
        chk(tag, nbad, 0);
    endtask

    // One transfer; rst_at>0 pulls reset low during that cycle after accept.
    task automatic run_xfer(input int s, input int d, input int l, input bit fl,
                            input logic [DW-1:0] fv, input bit poke, input int rst_at);
        logic [DW-1:0] exp_wd [1<<AW];
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        int lat, n_apply, cyc, busy_n, bad, dn0, we0, k;
        lat     = (l == 0) ? 1 : (fl ? l + 1 : 2 * l + 1);
        n_apply = (rst_at == 0) ? l : (fl ? rst_at : rst_at / 2);
        if (n_apply > l) n_apply = l;
        // Forward sequential copy: overlapping sources see earlier writes.
        for (int j = 0; j < l; j++) begin
            exp_wd[j] = fl ? fv : exp_ram[(s + j) & M];
            if (j < n_apply) exp_ram[(d + j) & M] = exp_wd[j];
        end
        dn0 = done_total; we0 = we_total;
        start = 1'b1; src = AW'(s); dst = AW'(d); len = AW'(l);
        fill = fl; fill_val = fv;
        @(posedge clk); #1;
        start = 1'b0;
        src = AW'($urandom); dst = AW'($urandom); len = AW'($urandom);
        fill = 1'($urandom); fill_val = DW'($urandom);
        cyc = 1; busy_n = 0; bad = 0;
        while (!done && cyc <= lat + 2) begin
            if (busy) busy_n++;
            if (cyc < lat) begin
                ewd = '0;
                if (fl) begin
                    k = cyc - 1; ea = AW'(d + k); ewe = 1'b1; ewd = fv;
                end else begin
                    k = (cyc - 1) / 2;
                    if (cyc % 2 == 1) begin ea = AW'(s + k); ewe = 1'b0; end
                    else begin ea = AW'(d + k); ewe = 1'b1; ewd = exp_wd[k]; end
                end
                if (bus.mem_addr !== ea || bus.mem_we !== ewe ||
                    (ewe && bus.mem_wdata !== ewd)) bad++;
            end
            if (cyc == rst_at) rst = 1'b0;
            start = poke && (cyc == 2);
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == rst_at) begin
                chk("rst_busy", busy, 0);
                chk("rst_we", bus.mem_we, 0);
                chk("rst_done", done, 0);
                chk("rst_proto", bad, 0);
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_no_done", done_total - dn0, 0);
                chk("rst_idle_busy", busy, 0);
                chk("rst_we_count", we_total - we0, n_apply);
                cmp_ram("rst_ram");
                return;
            end
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("busy_cycles", busy_n, lat - 1);
        chk("proto", bad, 0);
        chk("fin_busy", busy, 0);
        chk("fin_idle_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("done_count", done_total - dn0, 1);
        chk("we_count", we_total - we0, l);
        cmp_ram("ram");
    endtask

    initial begin
        int s, d, l;
        bit fl;
        rst = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_val = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_busy", busy, 0);
        chk("rst_state_done", done, 0);
        chk("rst_state_we", bus.mem_we, 0);
        chk("rst_state_addr", bus.mem_addr, 0);
        chk("rst_state_wdata", bus.mem_wdata, 0);
        rst = 1'b1;

        for (int i = 0; i <= M; i++) poke_ram(i, DW'($urandom));
        poke_ram(0, 16'h1111); poke_ram(1, 16'h2222);
        poke_ram(2, 16'h3333); poke_ram(3, 16'h4444);
        run_xfer(0, 'h40, 4, 1'b0, '0, 1'b0, 0);
        chk("copy_word3", ram['h43], 16'h4444);

        run_xfer(5, 'h50, 0, 1'b0, '0, 1'b0, 0);

        poke_ram('h7E, 16'hBEEF); poke_ram('h7F, 16'hCAFE);
        poke_ram('h00, 16'h0123); poke_ram('h01, 16'h4567);
        run_xfer('h7E, 'h10, 4, 1'b0, '0, 1'b0, 0);

        run_xfer('h60, 'h30, 4, 1'b0, '0, 1'b0, 4);
        run_xfer('h60, 'h30, 4, 1'b0, '0, 1'b0, 0);

        run_xfer(8, 'h20, 5, 1'b0, '0, 1'b1, 0);
        run_xfer(3, 5, 6, 1'b0, '0, 1'b0, 0);

`ifdef RAM_COPY_FILL_EN
        run_xfer(0, 'h20, 3, 1'b1, 16'hA5A5, 1'b0, 0);
        chk("fill_word2", ram['h22], 16'hA5A5);
`endif

        for (int n = 0; n < 25; n++) begin
            s = int'($urandom_range(0, M));
            d = int'($urandom_range(0, M));
            l = int'($urandom_range(0, 12));
`ifdef RAM_COPY_FILL_EN
            fl = 1'($urandom);
`else
            fl = 1'b0;
`endif
            run_xfer(s, d, l, fl, DW'($urandom), 1'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ram_copy_master.md
# ram_copy_master

Bus-initiator block that drives the single-port data RAM interface (write data, address, write enable, read data) to perform block transfers inside that RAM without processor involvement. It sits between the control logic and the RAM port. It accepts a source address, destination address and word count, performs the copy using the RAM's one-cycle synchronous-read protocol, then signals completion.

## Interface
Parameters:
- `DW`, 16, data word width; must match the RAM.
- `AW`, 13, address width; must match the RAM.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `src`  in  AW  source start address. Latched on an accepted `start`.
- `dst`  in  AW  destination start address. Latched on an accepted `start`.
- `len`  in  AW  word count. 0 is legal.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `mem_addr`  out  AW  address to the RAM.
- `mem_we`  out  1  write enable to the RAM, active-high.
- `mem_wdata`  out  DW  write data to the RAM.
- `mem_rdata`  in  DW  read data from the RAM. Valid in the cycle after a cycle with `mem_we`=0 and the address presented.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE:
  - `start`=1 and `len`≠0 → latch `src`, `dst`, `len` into `sa`, `da`, `cnt`; go to RD.
  - `start`=1 and `len`=0 → go to FIN.
- RD: `mem_addr`=`sa`, `mem_we`=0. The RAM latches its read address at the end of this cycle. Next state is WR.
- WR: `mem_addr`=`da`, `mem_we`=1, `mem_wdata`=`mem_rdata`, passed through combinationally. The RAM holds its read address while `mem_we`=1, so `mem_rdata` stays stable. At the end of the cycle:
  - `sa`+1, `da`+1, `cnt`−1.
  - If `cnt`==1, go to FIN; otherwise go to RD.
- FIN: `done`=1 for exactly this cycle. Next state is IDLE.
- `busy`=1 in RD and WR only. It is 0 in IDLE and FIN.
- Addresses increment modulo 2^AW. Crossing 2^AW−1 wraps to 0 with no error.
- Copy is forward-only (ascending addresses). If the regions overlap with `dst`>`src`, source words already overwritten are re-read; this is defined behaviour, not an error.
- `start` outside IDLE is ignored. No queueing.
- `src`, `dst`, `len` are ignored except in the cycle where `start` is accepted.
- Outside RD/WR: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Reset: state=IDLE. `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Internal `sa`, `da`, `cnt` are 0.
- Reset asserted mid-transfer: at the next edge return to IDLE with `mem_we`=0. No `done` pulse. A write in progress in that same cycle still completes in the RAM.
- `start` accepted at edge E0:
  - RD cycle for word k occupies cycle 2k+1 after E0.
  - WR cycle for word k occupies cycle 2k+2 after E0.
  - FIN occupies cycle 2·len+1.
  - Total latency from `start` to `done` is 2·len+1 cycles.
- `len`=0: `done` in cycle 1 after E0. No RAM access.
- A new `start` is accepted in the first IDLE cycle after FIN. Back-to-back start-to-start spacing is 2·len+2 cycles.

## Configuration
- `RAM_COPY_FILL_EN`: when defined, adds two inputs.
  - Ports: `fill` (in, 1) and `fill_val` (in, DW). Both are latched on `start`.
  - With `fill`=1, `src` is ignored and FSM alternates IDLE→WR→…→FIN. WR writes `fill_val` to `da` with `mem_we`=1, one word per cycle.
  - Fill latency from `start` to `done` is len+1 cycles. `busy` is high in WR.
  - With `fill`=0, behaviour is identical to copy mode.
- When undefined: the ports are absent, only copy mode exists, and no fill logic is synthesized.

## Test plan
- Preload RAM[0..3]=0x1111,0x2222,0x3333,0x4444. Issue `start`, `src`=0, `dst`=0x40, `len`=4:
  - RAM[0x40..0x43] equals the source words.
  - `done` arrives 9 cycles after `start`.
  - `busy` is high for 8 cycles.
- `len`=0 → `done` one cycle after `start`; `mem_we` never 1; RAM unchanged.
- `src`=0x7E, `dst`=0x10, `len`=4 with `AW`=7 → reads wrap through 0x7E, 0x7F, 0x00, 0x01; the written words match.
- Assert `rst`=0 during the WR of word 1 of a `len`=4 copy → IDLE next cycle, `busy`=0, no `done`, only words 0–1 written. Then a new `start` completes normally.
- Pulse `start` again while `busy` → ignored: no extra writes, and exactly one `done`.
- With `RAM_COPY_FILL_EN`: `fill`=1, `fill_val`=0xA5A5, `dst`=0x20, `len`=3 → RAM[0x20..0x22]=0xA5A5, `done` 4 cycles after `start`, no read cycles.
